// File: rtl/calc_op_sequencer_if.sv
// calc_op_sequencer_if: pin-level bus between the sequencer and the accumulator calculator.
interface calc_op_sequencer_if;
    logic [7:0] calc_operand;
    logic [3:0] calc_op;
    logic       calc_strobe;
    logic [7:0] calc_result;
    logic [2:0] calc_flags;
    modport master(output calc_operand, calc_op, calc_strobe, input calc_result, calc_flags);
    modport slave(input calc_operand, calc_op, calc_strobe, output calc_result, calc_flags);
endinterface

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: runs a loadable (opcode, operand) program on the calculator, one strobe per word.
module calc_op_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [11:0]         prog_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    input  logic                abort,
    input  logic                halt_on_ovf,
    calc_op_sequencer_if.master calc,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   pc,
    output logic [7:0]          result,
    output logic [2:0]          flags
);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PC  = ADDR_W'(1);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
    state_t          state;
    logic [11:0]     mem [DEPTH];
    logic [ADDR_W:0] len, len_in;
    logic            hov, strobe_q, illegal, last;
    logic [3:0]      op_q;
    logic [7:0]      operand_q;
    logic [11:0]     word;
    assign len_in  = prog_len > DEPTH_W ? DEPTH_W : prog_len;
    assign word    = mem[pc];
    assign illegal = word[11:8] == 4'hB || word[11:8] == 4'hC;
    assign last    = {1'b0, pc} == len - ONE_L;
    assign calc.calc_strobe  = strobe_q;
    assign calc.calc_op      = op_q;
    assign calc.calc_operand = operand_q;
    always_ff @(posedge clk)
        if (prog_we && !busy) mem[prog_addr] <= prog_data;
    // strobe and done default low so each is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            strobe_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            pc        <= '0;
            result    <= '0;
            flags     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            len       <= '0;
            hov       <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done     <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        len   <= len_in;
                        hov   <= halt_on_ovf;
                        error <= 1'b0;
                        pc    <= '0;
                        busy  <= len_in != '0;
                        done  <= len_in == '0;
                        state <= len_in == '0 ? DONE : FETCH;
                    end
                    FETCH: begin
                        op_q      <= word[11:8];
                        operand_q <= word[7:0];
                        strobe_q  <= !illegal;
                        error     <= illegal;
                        busy      <= !illegal;
                        done      <= illegal;
                        state     <= illegal ? DONE : ISSUE;
                    end
                    ISSUE: state <= WAIT;
                    WAIT: begin
                        result <= calc.calc_result;
                        flags  <= calc.calc_flags;
                        if ((hov && calc.calc_flags[2]) || last) begin
                            error <= hov && calc.calc_flags[2];
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pc    <= pc + ONE_PC;
                            state <= FETCH;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Micro-sequencer that drives the 8-bit accumulator calculator chip from a small loadable program of (opcode, operand) words.
- Issues each operation with a single-cycle execute strobe followed by a mandatory low cycle, which satisfies the calculator's once-per-high-pulse rule.
- Captures the result and flags after each operation; can halt on overflow.
- Sits between the host/test logic and the calculator's ui_in / uio_in / uo_out / uio_out pins.

Parameters:
DEPTH, 8, number of program words; power of two, 2..16
ADDR_W, 3, log2(DEPTH)

Ports:
clk  input  1  clock
rst_n  input  1  reset, active-low
prog_we  input  1  program write enable
prog_addr  input  ADDR_W  program write address
prog_data  input  12  {opcode[11:8], operand[7:0]}
prog_len  input  ADDR_W+1  number of words to run; sampled at start
start  input  1  begin run; level-sampled
abort  input  1  abandon run
halt_on_ovf  input  1  stop run when the overflow flag is returned; sampled at start
calc_operand  output  8  to calculator ui_in
calc_op  output  4  to calculator uio_in[4:1]
calc_strobe  output  1  to calculator uio_in[0]
calc_result  input  8  from calculator uo_out
calc_flags  input  3  from calculator uio_out[7:5]: {ovf, neg, zero}
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
error  output  1  last run ended on illegal opcode or overflow halt; sticky until next accepted start
pc  output  ADDR_W  index of current or last executed word
result  output  8  last captured calc_result
flags  output  3  last captured calc_flags

Behaviour:
- Reset (async, rst_n low): state IDLE; calc_strobe, busy, done, error = 0; pc, result, flags, calc_op, calc_operand = 0.
- Program memory is not reset.
- All outputs are registered.
- prog_we is honoured only when busy=0; writes while busy are dropped.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 and abort=0: latch prog_len (clamped to DEPTH) and halt_on_ovf, clear error, set busy, pc=0, go to FETCH.
  - Latched len of 0: go straight to DONE.
- FETCH:
  - Load calc_op and calc_operand from mem[pc]; they are held stable until the next FETCH.
  - Opcode 0xB or 0xC (unused): set error, go to DONE, no strobe issued.
  - Otherwise go to ISSUE.
- ISSUE: calc_strobe=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - calc_strobe=0.
  - At the exiting edge, capture calc_result into result and calc_flags into flags.
  - If halt_on_ovf is latched and calc_flags[2]=1: set error, go to DONE.
  - Else if pc = len-1: go to DONE.
  - Else pc+1, go to FETCH.
- DONE: done=1 and busy=0 for one cycle; return to IDLE.
- Latency:
  - 3 cycles per operation.
  - done is high in cycle 3*len+1 after the start-accepting edge; len=0 gives 1.
  - calc_strobe is never high on two consecutive cycles, and is always separated from the next strobe by at least 2 low cycles.
- abort=1 in any non-IDLE state: next edge goes to IDLE with calc_strobe=0, busy=0, done=0, error unchanged, result/flags unchanged.
  - If abort coincides with ISSUE, the calculator still sees that strobe cycle and the operation takes effect in the calculator.
  - abort has priority over start.
- start while busy: ignored.
- start held high after DONE: a new run begins from IDLE on the next cycle.
- pc never exceeds len-1; there is no wrap.
- Reset mid-run: immediate return to the reset state; the in-flight strobe drops asynchronously.

Test Plan:
- Bench instantiates the calculator with ena=1. Program {0x0,0x05},{0x0,0x03}, len=2, start from calculator state 0 -> result=0x08, flags=000, done in cycle 7, exactly 2 strobe pulses.
- Program {0x0,0x08},{0x1,0x08}, len=2 -> result=0x00, flags zero=1, error=0.
- Program {0x0,0x7F},{0x0,0x01}, halt_on_ovf=1, len=4 -> stops after word 1, pc=1, result=0x80, flags ovf=1 neg=1, error=1, only 2 strobes.
- Word 1 opcode 0xB, len=3 -> 1 strobe, error=1, pc=1, done pulse, result from word 0.
- Assert abort during WAIT of word 1 of a len=4 run -> busy=0 the next cycle, no further strobes, no done pulse.
- prog_we during busy to address 0 -> memory unchanged on re-run; start with len=0 -> done one cycle later, no strobe.
